oc8051_psw_stack: RTL and testbench
===================================

OC8051_PSW_STACK -- requirements
Module: oc8051_psw_stack

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of PSW context-stack entries; legal range 1..16.
REQ-002 Parameter PSW_ADDR, default 8'hD0, SHALL be the PSW SFR byte address; its bit-address block is PSW_ADDR[7:3].
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port wr, input, 1: SFR write strobe.
REQ-006 Port wr_bit, input, 1: 1 = bit-addressed write, 0 = byte write.
REQ-007 Port wr_addr, input, 8: SFR byte address, or bit address when wr_bit = 1.
REQ-008 Port data_in, input, 8: byte-write data.
REQ-009 Port cy_in / ac_in / ov_in, input, 1 each: ALU carry, aux-carry and overflow; cy_in is also the bit-write data.
REQ-010 Port p, input, 1: accumulator parity.
REQ-011 Port set, input, 2: flag update mode; 00 none, 01 CY, 10 CY+OV, 11 CY+AC+OV.
REQ-012 Port push / pop, input, 1 each: context save on interrupt entry / restore on RETI.
REQ-013 Port push_bank, input, 2: register bank selected by push.
REQ-014 Port err_clr, input, 1: clears the sticky error flags.
REQ-015 Port data_out, output, 8: {psw[7:1], p}.
REQ-016 Port bank_sel, output, 2: effective register bank, bypassed.
REQ-017 Port level, output, 5: number of occupied stack entries.
REQ-018 Ports full / empty, output, 1 each: level == DEPTH / level == 0.
REQ-019 Ports ovf_err / unf_err, output, 1 each: sticky push-when-full / pop-when-empty flags.

Function
REQ-020 The live register psw[7:1] SHALL use bit 7 = CY, 6 = AC, 5 = F0, 4:3 = RS1:RS0, 2 = OV, 1 = user; bit 0 is always the parity input p and SHALL NOT be stored.
REQ-021 A valid pop (pop = 1, empty = 0) SHALL load psw[7:1] from the top entry, decrement level, and override every write, set and push in the same cycle.
REQ-022 A valid push (push = 1, pop = 0, full = 0) SHALL store the pre-edge psw[7:1] at the top and increment level.
REQ-023 After a valid push, the byte-write, bit-write and set rules (REQ-024 to REQ-026) SHALL still apply to the live register, and then psw[4:3] SHALL be forced to push_bank.
REQ-024 Byte write (wr = 1, wr_bit = 0, wr_addr == PSW_ADDR): psw[7:1] <= data_in[7:1]; set SHALL be ignored that cycle.
REQ-025 Bit write (wr = 1, wr_bit = 1, wr_addr[7:3] == PSW_ADDR[7:3], wr_addr[2:0] != 0): psw[wr_addr[2:0]] <= cy_in; set SHALL be ignored; a bit write to bit 0 SHALL change nothing.
REQ-026 With no PSW write that cycle: set = 01 SHALL write CY; 10 SHALL write CY and OV; 11 SHALL write CY, AC and OV; 00 SHALL hold.
REQ-027 Push and pop in the same cycle: the pop SHALL take effect (if valid) and the push SHALL be dropped with no error flag.
REQ-028 Push while full: stack, level and bank SHALL be unchanged; writes and set proceed; ovf_err SHALL be set.
REQ-029 Pop while empty: no restore; writes and set proceed; unf_err SHALL be set.
REQ-030 The error flags SHALL stay set until err_clr or rst; a new error in the err_clr cycle SHALL take priority and leave its flag set.
REQ-031 bank_sel SHALL be combinational, by priority:
  - valid pop: top[4:3]
  - else valid push: push_bank
  - else byte write (REQ-024): data_in[4:3]
  - else psw[4:3]
REQ-032 A bit write to RS0 or RS1 SHALL NOT be bypassed; bank_sel follows it one cycle later.
REQ-033 full, empty and level SHALL be registered-state decodes with no same-cycle bypass.

Reset
REQ-034 While rst = 1 at a clk edge, psw[7:1] <= 0, level <= 0, ovf_err <= 0 and unf_err <= 0, overriding all other inputs.
REQ-035 After reset, data_out = {7'b0, p}, bank_sel = 0, empty = 1 and full = 0.
REQ-036 Stack entry contents need no reset.
REQ-037 A reset mid-nesting SHALL discard all saved contexts.

Verification
REQ-038 Byte write 8'hD0 with data 8'hFF, p = 0 -> data_out = 8'hFE next cycle; bank_sel = 3 in the write cycle.
REQ-039 Bit write to address 8'hD7 with cy_in = 1, set = 11 in the same cycle -> only CY set; AC and OV unchanged.
REQ-040 psw = 8'h88, push with push_bank = 2 -> psw[4:3] = 2, level = 1; a later pop -> psw restored to 8'h88, bank_sel = 1 during the pop cycle.
REQ-041 DEPTH + 1 pushes -> full = 1, ovf_err = 1, bank unchanged on the last push; DEPTH pops then restore in LIFO order; one further pop -> unf_err = 1.
REQ-042 Push and pop together at level 2 -> level = 1 and psw = popped entry; rst asserted at level 3 -> level = 0 and psw = 0 next cycle.

Source files
------------

// File: rtl/oc8051_psw_stack.sv
// oc8051_psw_stack: 8051 PSW register with a LIFO of saved PSW contexts for nested interrupts.
module oc8051_psw_stack #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PSW_ADDR = 8'hD0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic [7:0] wr_addr,
  input  logic [7:0] data_in,
  input  logic       cy_in,
  input  logic       ac_in,
  input  logic       ov_in,
  input  logic       p,
  input  logic [1:0] set,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] push_bank,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic [1:0] bank_sel,
  output logic [4:0] level,
  output logic       full,
  output logic       empty,
  output logic       ovf_err,
  output logic       unf_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:1] psw_q, psw_d, wr_v, top;
  logic [7:1] stack_q [DEPTH];
  logic [4:0] level_q, level_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic pop_v, push_v, byte_wr, bit_wr;
  logic [7:0] bit_mask;
  logic [AW-1:0] top_idx, push_idx;
  assign full     = level_q == 5'(DEPTH);
  assign empty    = level_q == 5'd0;
  assign pop_v    = pop & ~empty;
  assign push_v   = push & ~pop & ~full;
  assign byte_wr  = wr & ~wr_bit & (wr_addr == PSW_ADDR);
  assign bit_wr   = wr & wr_bit & (wr_addr[7:3] == PSW_ADDR[7:3]);
  assign bit_mask = 8'd1 << wr_addr[2:0];
  assign top_idx  = AW'(level_q - 5'd1);
  assign push_idx = AW'(level_q);
  assign top      = stack_q[top_idx];
  // A write to bit 0 has an empty mask over [7:1], so it changes nothing but still suppresses set
  always_comb begin
    wr_v = psw_q;
    if (byte_wr) wr_v = data_in[7:1];
    else if (bit_wr) wr_v = (psw_q & ~bit_mask[7:1]) | ({7{cy_in}} & bit_mask[7:1]);
    else begin
      wr_v[7] = set != 2'b00 ? cy_in : psw_q[7];
      wr_v[6] = set == 2'b11 ? ac_in : psw_q[6];
      wr_v[2] = set[1] ? ov_in : psw_q[2];
    end
    if (push_v) wr_v[4:3] = push_bank;
    psw_d = pop_v ? top : wr_v;
  end
  assign level_d = pop_v ? level_q - 5'd1 : push_v ? level_q + 5'd1 : level_q;
  assign ovf_d   = (push & ~pop & full) | (ovf_q & ~err_clr);
  assign unf_d   = (pop & empty) | (unf_q & ~err_clr);
  always_ff @(posedge clk) begin
    if (rst) begin
      psw_q   <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      psw_q   <= psw_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_v) stack_q[push_idx] <= psw_q;
  end
  assign data_out = {psw_q, p};
  assign bank_sel = pop_v ? top[4:3] : push_v ? push_bank : byte_wr ? data_in[4:3] : psw_q[4:3];
  assign level    = level_q;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;
endmodule

// File: tb/tb_oc8051_psw_stack.sv
// tb_oc8051_psw_stack: scoreboard bench for the PSW context stack against a behavioural model.
module tb_oc8051_psw_stack;
  localparam int DEPTH = 4;
  logic clk = 0, rst, wr, wr_bit, cy_in, ac_in, ov_in, p, push, pop, err_clr;
  logic [7:0] wr_addr, data_in;
  logic [1:0] set, push_bank;
  logic [7:0] data_out;
  logic [1:0] bank_sel;
  logic [4:0] level;
  logic full, empty, ovf_err, unf_err;
  int checks = 0, failures = 0;
  typedef struct {logic [7:0] dout; logic [4:0] lvl; logic f, e, o, u;} exp_t;
  exp_t sb[$];
  logic [7:0] m_psw, m_stk [16];
  int m_lvl;
  logic m_ovf, m_unf;

  oc8051_psw_stack #(.DEPTH(DEPTH), .PSW_ADDR(8'hD0)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in),
    .cy_in(cy_in), .ac_in(ac_in), .ov_in(ov_in), .p(p), .set(set), .push(push), .pop(pop),
    .push_bank(push_bank), .err_clr(err_clr), .data_out(data_out), .bank_sel(bank_sel),
    .level(level), .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {rst, wr, wr_bit, cy_in, ac_in, ov_in, push, pop, err_clr} = '0;
    wr_addr = 8'h00; data_in = 8'h00; set = 2'b00; push_bank = 2'b00;
  endtask

  task automatic tick();
    exp_t e;
    logic [7:0] n;
    logic vp, vu, bw, bt, on, un;
    logic [1:0] eb;
    #1;
    vp = pop && m_lvl > 0;
    vu = push && !pop && m_lvl < DEPTH;
    bw = wr && !wr_bit && wr_addr == 8'hD0;
    bt = wr && wr_bit && wr_addr[7:3] == 5'b11010;
    eb = vp ? m_stk[m_lvl-1][4:3] : vu ? push_bank : bw ? data_in[4:3] : m_psw[4:3];
    check("bank_sel", {30'b0, bank_sel}, {30'b0, eb});
    on = push && !pop && m_lvl == DEPTH;
    un = pop && m_lvl == 0;
    n = m_psw;
    if (bw) n = {data_in[7:1], 1'b0};
    else if (bt) begin
      if (wr_addr[2:0] != 3'd0) n[wr_addr[2:0]] = cy_in;
    end else begin
      if (set != 2'b00) n[7] = cy_in;
      if (set == 2'b11) n[6] = ac_in;
      if (set == 2'b10 || set == 2'b11) n[2] = ov_in;
    end
    if (vu) begin
      m_stk[m_lvl] = m_psw;
      n[4:3] = push_bank;
      m_lvl++;
    end
    if (vp) begin
      m_lvl--;
      n = m_stk[m_lvl];
    end
    m_psw = n;
    m_ovf = on || (m_ovf && !err_clr);
    m_unf = un || (m_unf && !err_clr);
    if (rst) begin
      m_psw = 0; m_lvl = 0; m_ovf = 0; m_unf = 0;
    end
    e.dout = {m_psw[7:1], p};
    e.lvl = 5'(m_lvl);
    e.f = m_lvl == DEPTH;
    e.e = m_lvl == 0;
    e.o = m_ovf;
    e.u = m_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("data_out", {24'b0, data_out}, {24'b0, e.dout});
    check("level", {27'b0, level}, {27'b0, e.lvl});
    check("full", {31'b0, full}, {31'b0, e.f});
    check("empty", {31'b0, empty}, {31'b0, e.e});
    check("ovf_err", {31'b0, ovf_err}, {31'b0, e.o});
    check("unf_err", {31'b0, unf_err}, {31'b0, e.u});
  endtask

  task automatic byte_wr(input logic [7:0] d);
    idle(); wr = 1; wr_addr = 8'hD0; data_in = d;
    tick();
  endtask

  initial begin
    idle(); p = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_psw = 0; m_lvl = 0; m_ovf = 0; m_unf = 0;
    rst = 0; p = 1;
    #1;
    check("rst_dout", {24'b0, data_out}, 32'h01);
    check("rst_bank", {30'b0, bank_sel}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_level", {27'b0, level}, 32'd0);
    check("rst_err", {30'b0, ovf_err, unf_err}, 32'd0);
    // byte write FF with p=0
    idle(); p = 0; wr = 1; wr_addr = 8'hD0; data_in = 8'hFF;
    #1;
    check("bw_bank", {30'b0, bank_sel}, 32'd3);
    tick();
    check("bw_dout", {24'b0, data_out}, 32'hFE);
    byte_wr(8'h00);
    idle(); set = 2'b11; cy_in = 1; ac_in = 1; ov_in = 1;
    tick();
    check("set11", {24'b0, data_out}, 32'hC4);
    byte_wr(8'h00);
    idle(); set = 2'b10; cy_in = 1; ac_in = 1; ov_in = 1;
    tick();
    check("set10", {24'b0, data_out}, 32'h84);
    byte_wr(8'h00);
    // bit write CY ignores set
    idle(); wr = 1; wr_bit = 1; wr_addr = 8'hD7; cy_in = 1; set = 2'b11; ac_in = 1; ov_in = 1;
    tick();
    check("bit_cy", {24'b0, data_out}, 32'h80);
    idle(); wr = 1; wr_bit = 1; wr_addr = 8'hD0; cy_in = 1; set = 2'b11; ac_in = 1; ov_in = 1;
    tick();
    check("bit0", {24'b0, data_out}, 32'h80);
    idle(); wr = 1; wr_bit = 1; wr_addr = 8'hD3; cy_in = 1;
    #1;
    check("rs0_nobyp", {30'b0, bank_sel}, 32'd0);
    tick();
    check("rs0_late", {30'b0, bank_sel}, 32'd1);
    // context save / restore
    byte_wr(8'h88);
    idle(); push = 1; push_bank = 2;
    tick();
    check("push_dout", {24'b0, data_out}, 32'h90);
    check("push_lvl", {27'b0, level}, 32'd1);
    idle(); pop = 1;
    #1;
    check("pop_bank", {30'b0, bank_sel}, 32'd1);
    tick();
    check("pop_dout", {24'b0, data_out}, 32'h88);
    // fill past full
    for (int k = 0; k < DEPTH; k++) begin
      idle(); push = 1; push_bank = 2'(k); wr = 1; wr_addr = 8'hD0; data_in = 8'(8'h25 * (k + 1));
      tick();
    end
    idle(); push = 1; push_bank = 2'd1;
    #1;
    check("ovf_bank", {30'b0, bank_sel}, 32'd3);
    tick();
    check("ovf_full", {31'b0, full}, 32'd1);
    check("ovf_flag", {31'b0, ovf_err}, 32'd1);
    check("ovf_keep", {30'b0, bank_sel}, 32'd3);
    for (int k = 0; k < DEPTH; k++) begin
      idle(); pop = 1;
      tick();
    end
    check("lifo_last", {24'b0, data_out}, 32'h88);
    idle(); pop = 1;
    tick();
    check("unf_flag", {31'b0, unf_err}, 32'd1);
    idle(); err_clr = 1;
    tick();
    check("clr", {30'b0, ovf_err, unf_err}, 32'd0);
    idle(); err_clr = 1; pop = 1;
    tick();
    check("clr_prio", {31'b0, unf_err}, 32'd1);
    idle(); err_clr = 1;
    tick();
    // push+pop at level 2, then reset at level 3
    for (int k = 0; k < 2; k++) begin
      idle(); push = 1; push_bank = 2'(k + 1);
      tick();
    end
    idle(); push = 1; pop = 1; push_bank = 2'd3;
    tick();
    check("pp_lvl", {27'b0, level}, 32'd1);
    check("pp_noerr", {31'b0, ovf_err}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      idle(); push = 1; push_bank = 2'(k);
      tick();
    end
    check("lvl3", {27'b0, level}, 32'd3);
    idle(); rst = 1; push = 1; wr = 1; wr_addr = 8'hD0; data_in = 8'hFF;
    tick();
    check("mid_rst_lvl", {27'b0, level}, 32'd0);
    check("mid_rst_dout", {24'b0, data_out}, 32'h00);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = $urandom_range(0, 49) == 0;
      wr = $urandom_range(0, 2) == 0;
      wr_bit = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: wr_addr = 8'hD0;
        1: wr_addr = {5'b11010, 3'($urandom_range(0, 7))};
        2: wr_addr = 8'hE0;
        default: wr_addr = 8'($urandom);
      endcase
      data_in = 8'($urandom);
      {cy_in, ac_in, ov_in} = 3'($urandom);
      p = 1'($urandom);
      set = 2'($urandom);
      push = $urandom_range(0, 3) == 0;
      pop = $urandom_range(0, 3) == 0;
      push_bank = 2'($urandom);
      err_clr = $urandom_range(0, 9) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
